// File: rtl/stream_mux_rr_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
package stream_mux_rr_pkg;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: owns the last-grant pointer and supports holding a grant.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_idx,
  input  logic             advance,
  input  logic [SEL_W-1:0] adv_idx,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= SEL_W'(N_CH - 1);
    end else if (advance) begin
      r_last_grant <= adv_idx;
    end
  end

  // Offsets are scanned from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (lock_en) begin
      grant_idx = lock_idx;
      for (int i = 0; i < N_CH; i++) begin
        if (lock_idx == SEL_W'(i)) grant_valid = req[i];
      end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        for (int i = 0; i < N_CH; i++) begin
          if (((int'(r_last_grant) + k) % N_CH) == i && req[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with round-robin arbitration, optional packet
// lock and a single registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter int PKT_MODE = 0,
  localparam int SEL_W   = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_sel
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;

  logic             w_can_accept;
  logic             w_gvalid;
  logic [SEL_W-1:0] w_gidx;
  logic             w_vld_g;
  logic             w_last_g;
  logic [W-1:0]     w_data_g;
  logic             w_accept;
  logic             w_advance;
  logic             w_lock_en;

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_lock_en    = (PKT_MODE != 0) && r_lock;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (in_valid),
    .lock_en    (w_lock_en),
    .lock_idx   (r_lock_idx),
    .advance    (w_advance),
    .adv_idx    (w_gidx),
    .grant_valid(w_gvalid),
    .grant_idx  (w_gidx)
  );

  always_comb begin
    w_vld_g  = 1'b0;
    w_last_g = 1'b0;
    w_data_g = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gidx == SEL_W'(i)) begin
        w_vld_g  = in_valid[i];
        w_last_g = in_last[i];
        w_data_g = in_data[i*W +: W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rdy
      assign in_ready[gi] = w_can_accept && w_gvalid && (w_gidx == SEL_W'(gi));
    end
  endgenerate

  assign w_accept  = w_can_accept && w_gvalid && w_vld_g;
  // Mid-packet beats leave the pointer alone; only the closing beat moves it.
  assign w_advance = w_accept && ((PKT_MODE == 0) || w_last_g);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data_g;
        r_out_last  <= (PKT_MODE != 0) ? w_last_g : 1'b0;
        r_out_sel   <= w_gidx;
        if (PKT_MODE != 0) begin
          r_lock     <= !w_last_g;
          r_lock_idx <= w_gidx;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench: one beat-per-beat mux (d0) and one packet-mode mux (d1).
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  iv0, ir0, il0, iv1, ir1, il1;
  logic [31:0] id0, id1;
  logic        ov0, or0, ol0, ov1, or1, ol1;
  logic [7:0]  od0, od1;
  logic [1:0]  os0, os1;

  int errors = 0;
  int checks = 0;

  stream_mux_rr #(.N_CH(4), .W(8), .PKT_MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .in_last(il0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_last(ol0), .out_sel(os0)
  );

  stream_mux_rr #(.N_CH(4), .W(8), .PKT_MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .out_sel(os1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d0(input int k);
    for (int i = 0; i < 4; i++) id0[i*8 +: 8] = 8'(i*16 + k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv0 = '0; il0 = '0; id0 = '0; or0 = 1'b1;
    iv1 = '0; il1 = '0; id1 = '0; or1 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ov0 !== 1'b0 || ir0 !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle_d0 cyc%0d got ov=%b rdy=%b exp ov=0 rdy=0000", c, ov0, ir0);
      end
      checks++;
      if (ov1 !== 1'b0 || ir1 !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle_d1 cyc%0d got ov=%b rdy=%b exp ov=0 rdy=0000", c, ov1, ir1);
      end
      checks++;
      if (od0 !== 8'h00 || os0 !== 2'd0 || ol0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_fields cyc%0d got data=%h sel=%0d last=%b exp 00/0/0", c, od0, os0, ol0);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp_sel [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    or0 = 1'b1;
    iv0 = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      set_d0(c);
      exp_rdy = 4'b0001 << exp_sel[c];
      exp_dat = 8'(exp_sel[c]*16 + c);
      #1;
      checks++;
      if (ir0 !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready beat%0d got=%b exp=%b", c, ir0, exp_rdy);
      end
      if (c == 0) begin
        checks++;
        if (ov0 !== 1'b0) begin
          errors++;
          $display("FAIL rr_latency got ov=%b exp=0", ov0);
        end
      end
      tick();
      checks++;
      if (ov0 !== 1'b1 || os0 !== 2'(exp_sel[c]) || od0 !== exp_dat) begin
        errors++;
        $display("FAIL rr_out beat%0d got ov=%b sel=%0d data=%h exp ov=1 sel=%0d data=%h",
                 c, ov0, os0, od0, exp_sel[c], exp_dat);
      end
    end
  endtask

  task automatic test_backpressure();
    set_d0(1);
    #1;
    checks++;
    if (ir0 !== 4'b0100) begin
      errors++;
      $display("FAIL bp_pre_ready got=%b exp=0100", ir0);
    end
    tick();
    checks++;
    if (od0 !== 8'h21 || os0 !== 2'd2) begin
      errors++;
      $display("FAIL bp_load got data=%h sel=%0d exp data=21 sel=2", od0, os0);
    end
    or0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ir0 !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall_ready cyc%0d got=%b exp=0000", c, ir0);
      end
      tick();
      checks++;
      if (ov0 !== 1'b1 || od0 !== 8'h21 || os0 !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got ov=%b data=%h sel=%0d exp ov=1 data=21 sel=2",
                 c, ov0, od0, os0);
      end
    end
    or0 = 1'b1;
    #1;
    checks++;
    if (ir0 !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready got=%b exp=1000", ir0);
    end
    tick();
    checks++;
    if (ov0 !== 1'b1 || od0 !== 8'h31 || os0 !== 2'd3) begin
      errors++;
      $display("FAIL bp_release got ov=%b data=%h sel=%0d exp ov=1 data=31 sel=3", ov0, od0, os0);
    end
    iv0 = 4'b0000;
    tick();
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got ov=%b exp=0", ov0);
    end
  endtask

  task automatic test_sparse();
    set_d0(2);
    iv0 = 4'b1000;
    #1;
    checks++;
    if (ir0 !== 4'b1000) begin
      errors++;
      $display("FAIL sparse_ch3_ready got=%b exp=1000", ir0);
    end
    tick();
    checks++;
    if (os0 !== 2'd3 || od0 !== 8'h32) begin
      errors++;
      $display("FAIL sparse_ch3 got sel=%0d data=%h exp sel=3 data=32", os0, od0);
    end
    iv0 = 4'b0001;
    #1;
    checks++;
    if (ir0 !== 4'b0001) begin
      errors++;
      $display("FAIL sparse_wrap_ready got=%b exp=0001", ir0);
    end
    tick();
    checks++;
    if (os0 !== 2'd0 || od0 !== 8'h02) begin
      errors++;
      $display("FAIL sparse_wrap got sel=%0d data=%h exp sel=0 data=02", os0, od0);
    end
    iv0 = 4'b0010;
    tick();
    iv0 = 4'b0101;
    #1;
    checks++;
    if (ir0 !== 4'b0100) begin
      errors++;
      $display("FAIL sparse_prio_ready got=%b exp=0100", ir0);
    end
    tick();
    checks++;
    if (os0 !== 2'd2 || od0 !== 8'h22) begin
      errors++;
      $display("FAIL sparse_prio got sel=%0d data=%h exp sel=2 data=22", os0, od0);
    end
    #1;
    checks++;
    if (ir0 !== 4'b0001) begin
      errors++;
      $display("FAIL sparse_next_ready got=%b exp=0001", ir0);
    end
    tick();
    checks++;
    if (os0 !== 2'd0) begin
      errors++;
      $display("FAIL sparse_next got sel=%0d exp sel=0", os0);
    end
    iv0 = 4'b0000;
    tick();
  endtask

  task automatic test_packet_lock();
    logic [7:0] beat_dat [3] = '{8'h11, 8'h12, 8'h13};
    or1 = 1'b1;
    id1 = '0;
    id1[23:16] = 8'h2A;
    for (int b = 0; b < 3; b++) begin
      iv1 = 4'b0110;
      il1 = (b == 2) ? 4'b0010 : 4'b0000;
      id1[15:8] = beat_dat[b];
      #1;
      checks++;
      if (ir1 !== 4'b0010) begin
        errors++;
        $display("FAIL pkt_ready beat%0d got=%b exp=0010", b, ir1);
      end
      tick();
      checks++;
      if (ov1 !== 1'b1 || os1 !== 2'd1 || od1 !== beat_dat[b] || ol1 !== (b == 2)) begin
        errors++;
        $display("FAIL pkt_beat%0d got ov=%b sel=%0d data=%h last=%b exp ov=1 sel=1 data=%h last=%b",
                 b, ov1, os1, od1, ol1, beat_dat[b], (b == 2));
      end
      if (b == 0) begin
        iv1 = 4'b0100;
        il1 = 4'b0000;
        #1;
        checks++;
        if (ir1[2] !== 1'b0) begin
          errors++;
          $display("FAIL pkt_gap_ready2 got=%b exp=0", ir1[2]);
        end
        tick();
        checks++;
        if (ov1 !== 1'b0) begin
          errors++;
          $display("FAIL pkt_gap_out got ov=%b exp=0", ov1);
        end
      end
    end
    iv1 = 4'b0100;
    il1 = 4'b0100;
    #1;
    checks++;
    if (ir1 !== 4'b0100) begin
      errors++;
      $display("FAIL pkt_unlock_ready got=%b exp=0100", ir1);
    end
    tick();
    checks++;
    if (os1 !== 2'd2 || od1 !== 8'h2A) begin
      errors++;
      $display("FAIL pkt_unlock got sel=%0d data=%h exp sel=2 data=2a", os1, od1);
    end
    iv1 = 4'b0000;
    il1 = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    iv1 = 4'b0010;
    il1 = 4'b0000;
    id1[15:8] = 8'h51;
    #1;
    checks++;
    if (ir1 !== 4'b0010) begin
      errors++;
      $display("FAIL rstpkt_ready got=%b exp=0010", ir1);
    end
    tick();
    id1[15:8] = 8'h52;
    tick();
    checks++;
    if (os1 !== 2'd1 || od1 !== 8'h52) begin
      errors++;
      $display("FAIL rstpkt_beat2 got sel=%0d data=%h exp sel=1 data=52", os1, od1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("FAIL rstpkt_out got ov=%b exp=0", ov1);
    end
    iv1 = 4'b1100;
    #1;
    checks++;
    if (ir1 !== 4'b0100) begin
      errors++;
      $display("FAIL rstpkt_regrant_ready got=%b exp=0100", ir1);
    end
    tick();
    checks++;
    if (ov1 !== 1'b1 || os1 !== 2'd2) begin
      errors++;
      $display("FAIL rstpkt_regrant got ov=%b sel=%0d exp ov=1 sel=2", ov1, os1);
    end
    iv1 = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_packet_lock();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshakes on every input and on the output.
- Replaces the fixed select-driven muxes with a built-in round-robin arbiter and a registered output stage.
- Optional packet mode keeps a grant on one channel until that channel's last beat has been accepted.
- Sits between several producers and a single consumer, e.g. merging per-lane result streams into one bus.

Parameters:
- N_CH, 4, number of input channels, 1..16.
- W, 8, data width per channel in bits.
- PKT_MODE, 0, 0 = re-arbitrate after every beat; 1 = hold grant until a beat with in_last=1 is accepted.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; at most one bit high in any cycle.
- in_data  input  N_CH*W  flattened data; channel i occupies bits [i*W +: W].
- in_last  input  N_CH  per-channel end-of-packet flag; ignored when PKT_MODE=0.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  W  registered data.
- out_last  output  1  registered copy of in_last of the accepted beat.
- out_sel  output  SEL_W  index of the source channel; SEL_W = (N_CH>1) ? $clog2(N_CH) : 1.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Round-robin pointer set so channel 0 has top priority: last_grant=N_CH-1.
  - Packet lock cleared.
  - A reset mid-packet discards the lock; no partial state survives.
- can_accept = !out_valid || out_ready (single-entry register, bypass on drain).
- Grant selection is combinational:
  - Lock inactive: the first channel with in_valid=1, searching (last_grant+1) mod N_CH upward with wrap.
  - Lock active: the locked channel only, even if its in_valid=0. Other channels wait.
- in_ready[g] = can_accept && grant_valid, where g = grant. All other in_ready bits are 0. in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Accept at a posedge when in_valid[g] && in_ready[g]:
  - out_data<=in_data[g], out_last<=in_last[g], out_sel<=g, out_valid<=1.
  - Latency is 1 cycle input to output. Throughput is 1 beat/cycle while out_ready=1.
- Output drained with no accept (out_valid && out_ready and no input handshake): out_valid<=0. Data fields hold their values; don't-care.
- Pointer update on accept:
  - PKT_MODE=0: last_grant<=g.
  - PKT_MODE=1: if in_last[g]=1, last_grant<=g and the lock is cleared; else lock<=1 on channel g.
- Output stall (out_valid && !out_ready):
  - All in_ready=0.
  - out_data, out_last and out_sel are held stable.
  - Pointer and lock are unchanged.
- No in_valid high: no grant, all in_ready=0, pointer unchanged.
- N_CH=1: degenerates to a one-stage pipeline register; out_sel is always 0.
- Fairness: with all channels continuously valid and PKT_MODE=0, each channel is granted exactly once in every N_CH accepts.

Decomposition:
- No package typedefs are needed. SEL_W is a localparam in the module.
- One sub-module, rr_arbiter (parameter N_CH):
  - Inputs: clk, rst, req[N_CH], lock_en, lock_idx, advance, adv_idx.
  - Outputs: grant_valid, grant_idx.
  - Owns the pointer.
- The top level owns the output register, the ready logic and the lock flag.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, all in_valid=0 → out_valid=0, in_ready=0000 on every cycle after reset.
- Round-robin (PKT_MODE=0, N_CH=4): in_valid=1111 held, in_data = i*16+k, out_ready=1 → out_sel sequence 0,1,2,3,0,1 on consecutive cycles, first out_valid one cycle after the first accept.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with data 0x21 → out_data stays 0x21, in_ready=0000. On release, the next beat comes from channel 3 with no beat lost or duplicated.
- Packet lock (PKT_MODE=1): ch1 sends 3 beats with last on beat 3, ch2 constantly valid → out_sel=1,1,1 then 2. A one-cycle gap in ch1 valid mid-packet gives in_ready[2]=0.
- Sparse requests: only ch3 valid, then only ch0 → grants 3 then 0 (wrap). A channel 2 request arriving with channel 0 pending after last_grant=1 → channel 2 wins.
- Reset mid-packet (PKT_MODE=1): assert rst after beat 2 of a ch1 packet → lock cleared, out_valid=0. The first grant after reset goes to the lowest valid channel.
